// File: rtl/reorder_buffer_if.sv
// Core <-> reorder buffer bundle: dispatch, CDB writeback, operand lookup, flush and retire.
// Multi-port fields are flat vectors with port 0 in the least significant slice.
interface reorder_buffer_if #(
  parameter int ROB_SIZE       = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TAG_WIDTH      = $clog2(ROB_SIZE + 1),
  parameter int CDB_PORTS      = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int LOOKUP_PORTS   = 2
);
  logic                                   dispatch_valid;
  logic [REG_ADDR_WIDTH-1:0]              dispatch_rd;
  logic                                   dispatch_regwr;
  logic [63:0]                            dispatch_pc;
  logic                                   dispatch_ready;
  logic [TAG_WIDTH-1:0]                   dispatch_tag;

  logic [CDB_PORTS-1:0]                   cdb_valid;
  logic [CDB_PORTS*TAG_WIDTH-1:0]         cdb_tag;
  logic [CDB_PORTS*DATA_WIDTH-1:0]        cdb_value;

  logic [LOOKUP_PORTS*TAG_WIDTH-1:0]      lookup_tag;
  logic [LOOKUP_PORTS-1:0]                lookup_ready;
  logic [LOOKUP_PORTS*DATA_WIDTH-1:0]     lookup_value;

  logic                                   flush_valid;
  logic [TAG_WIDTH-1:0]                   flush_tag;
  logic                                   flush_all;

  logic [RETIRE_WIDTH-1:0]                retire_valid;
  logic [RETIRE_WIDTH*TAG_WIDTH-1:0]      retire_tag;
  logic [RETIRE_WIDTH*REG_ADDR_WIDTH-1:0] retire_rd;
  logic [RETIRE_WIDTH-1:0]                retire_regwr;
  logic [RETIRE_WIDTH*DATA_WIDTH-1:0]     retire_value;
  logic [RETIRE_WIDTH*64-1:0]             retire_pc;

  logic [TAG_WIDTH-1:0]                   count;
  logic                                   empty;
  logic                                   full;

  modport master (
    output dispatch_valid, dispatch_rd, dispatch_regwr, dispatch_pc,
    output cdb_valid, cdb_tag, cdb_value, lookup_tag,
    output flush_valid, flush_tag, flush_all,
    input  dispatch_ready, dispatch_tag, lookup_ready, lookup_value,
    input  retire_valid, retire_tag, retire_rd, retire_regwr, retire_value, retire_pc,
    input  count, empty, full
  );

  modport slave (
    input  dispatch_valid, dispatch_rd, dispatch_regwr, dispatch_pc,
    input  cdb_valid, cdb_tag, cdb_value, lookup_tag,
    input  flush_valid, flush_tag, flush_all,
    output dispatch_ready, dispatch_tag, lookup_ready, lookup_value,
    output retire_valid, retire_tag, retire_rd, retire_regwr, retire_value, retire_pc,
    output count, empty, full
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: slot i always carries tag i+1, tag 0 means "no tag".
// In-order multi-lane retire, CDB capture with bypassed lookup, selective and full flush.
module reorder_buffer #(
  parameter int ROB_SIZE       = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TAG_WIDTH      = $clog2(ROB_SIZE + 1),
  parameter int CDB_PORTS      = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int LOOKUP_PORTS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  reorder_buffer_if.slave  rob_if
);
  localparam int IDXW = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

  typedef logic [IDXW-1:0]      idx_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;

  logic [ROB_SIZE-1:0]       busy_q, busy_d, ready_q, ready_d, regwr_q, regwr_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q    [ROB_SIZE];
  logic [REG_ADDR_WIDTH-1:0] rd_d    [ROB_SIZE];
  logic [63:0]               pc_q    [ROB_SIZE];
  logic [63:0]               pc_d    [ROB_SIZE];
  logic [DATA_WIDTH-1:0]     value_q [ROB_SIZE];
  logic [DATA_WIDTH-1:0]     value_d [ROB_SIZE];
  idx_t                      head_q, head_d, tail_q, tail_d;
  tag_t                      count_q, count_d;

  function automatic idx_t wrap_add(input idx_t p, input int n);
    int t;
    t = int'(p) + n;
    if (t >= ROB_SIZE) t = t - ROB_SIZE;
    return idx_t'(t);
  endfunction

  // Age is distance from head, so wrapped pointers compare correctly.
  function automatic int age_of(input idx_t s, input idx_t h);
    if (s >= h) return int'(s) - int'(h);
    return int'(s) + ROB_SIZE - int'(h);
  endfunction

  function automatic logic tag_ok(input tag_t t);
    return (t != '0) && (int'(t) <= ROB_SIZE);
  endfunction

  function automatic idx_t tag2idx(input tag_t t);
    return idx_t'(int'(t) - 1);
  endfunction

  logic                  full_w, disp_acc, flush_en;
  idx_t                  flush_idx;
  int                    flush_age;
  logic [ROB_SIZE-1:0]   flushed;
  logic [CDB_PORTS-1:0]  cdb_hit;
  idx_t                  cdb_idx [CDB_PORTS];
  logic [RETIRE_WIDTH-1:0] ret_v;
  idx_t                  ret_idx [RETIRE_WIDTH];
  int                    ret_n;

  assign full_w                = (int'(count_q) == ROB_SIZE);
  assign rob_if.full           = full_w;
  assign rob_if.empty          = (count_q == '0);
  assign rob_if.count          = count_q;
  assign rob_if.dispatch_ready = !full_w && !rob_if.flush_valid && !rob_if.flush_all;
  assign rob_if.dispatch_tag   = tag_t'(int'(tail_q) + 1);
  assign disp_acc              = rob_if.dispatch_valid && rob_if.dispatch_ready;

  always_comb begin
    flush_idx = tag2idx(rob_if.flush_tag);
    flush_en  = rob_if.flush_valid && !rob_if.flush_all &&
                tag_ok(rob_if.flush_tag) && busy_q[flush_idx];
    flush_age = age_of(flush_idx, head_q);
    for (int s = 0; s < ROB_SIZE; s++) begin
      flushed[s] = flush_en && busy_q[s] && (age_of(idx_t'(s), head_q) > flush_age);
    end
  end

  always_comb begin
    tag_t t;
    for (int c = 0; c < CDB_PORTS; c++) begin
      t          = rob_if.cdb_tag[c*TAG_WIDTH +: TAG_WIDTH];
      cdb_idx[c] = tag2idx(t);
      cdb_hit[c] = rob_if.cdb_valid[c] && tag_ok(t) && busy_q[cdb_idx[c]] &&
                   !flushed[cdb_idx[c]] && !rob_if.flush_all;
    end
  end

  // Lookup bypasses same-cycle CDB traffic; scanning high-to-low lets the lowest channel win.
  always_comb begin
    tag_t                  lt;
    idx_t                  li;
    logic                  lr;
    logic [DATA_WIDTH-1:0] lv;
    rob_if.lookup_ready = '0;
    rob_if.lookup_value = '0;
    for (int p = 0; p < LOOKUP_PORTS; p++) begin
      lt = rob_if.lookup_tag[p*TAG_WIDTH +: TAG_WIDTH];
      li = tag2idx(lt);
      lr = 1'b0;
      lv = '0;
      if (tag_ok(lt) && busy_q[li]) begin
        lr = ready_q[li];
        lv = value_q[li];
        for (int c = CDB_PORTS - 1; c >= 0; c--) begin
          if (rob_if.cdb_valid[c] && (rob_if.cdb_tag[c*TAG_WIDTH +: TAG_WIDTH] == lt)) begin
            lr = 1'b1;
            lv = rob_if.cdb_value[c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      rob_if.lookup_ready[p]                          = lr;
      rob_if.lookup_value[p*DATA_WIDTH +: DATA_WIDTH] = lv;
    end
  end

  always_comb begin
    logic chain;
    chain               = !rob_if.flush_all;
    ret_v               = '0;
    ret_n               = 0;
    rob_if.retire_tag   = '0;
    rob_if.retire_rd    = '0;
    rob_if.retire_regwr = '0;
    rob_if.retire_value = '0;
    rob_if.retire_pc    = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      ret_idx[k] = wrap_add(head_q, k % ROB_SIZE);
      if (chain && (k < ROB_SIZE) && busy_q[ret_idx[k]] && ready_q[ret_idx[k]] &&
          !flushed[ret_idx[k]]) begin
        ret_v[k] = 1'b1;
        ret_n    = ret_n + 1;
        rob_if.retire_tag[k*TAG_WIDTH +: TAG_WIDTH]               = tag_t'(int'(ret_idx[k]) + 1);
        rob_if.retire_rd[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]      = rd_q[ret_idx[k]];
        rob_if.retire_regwr[k]                                    = regwr_q[ret_idx[k]];
        rob_if.retire_value[k*DATA_WIDTH +: DATA_WIDTH]           = value_q[ret_idx[k]];
        rob_if.retire_pc[k*64 +: 64]                              = pc_q[ret_idx[k]];
      end else begin
        chain = 1'b0;
      end
    end
    rob_if.retire_valid = ret_v;
  end

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    regwr_d = regwr_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    value_d = value_q;
    head_d  = wrap_add(head_q, ret_n);
    tail_d  = tail_q;
    count_d = tag_t'(int'(count_q) + int'(disp_acc) - ret_n);

    for (int c = CDB_PORTS - 1; c >= 0; c--) begin
      if (cdb_hit[c]) begin
        ready_d[cdb_idx[c]] = 1'b1;
        value_d[cdb_idx[c]] = rob_if.cdb_value[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (ret_v[k]) begin
        busy_d[ret_idx[k]]  = 1'b0;
        ready_d[ret_idx[k]] = 1'b0;
      end
    end
    busy_d  = busy_d & ~flushed;
    ready_d = ready_d & ~flushed;

    if (disp_acc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      regwr_d[tail_q] = rob_if.dispatch_regwr;
      rd_d[tail_q]    = rob_if.dispatch_rd;
      pc_d[tail_q]    = rob_if.dispatch_pc;
      tail_d          = wrap_add(tail_q, 1);
    end

    if (rob_if.flush_all) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (flush_en) begin
      // Survivors are head..F inclusive, less whatever retires this edge.
      tail_d  = wrap_add(flush_idx, 1);
      count_d = tag_t'(flush_age + 1 - ret_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= '0;
      ready_q <= '0;
      regwr_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      regwr_q <= regwr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by busy/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_q    <= rd_d;
    pc_q    <= pc_d;
    value_q <= value_d;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scenario bench for reorder_buffer; retirements are checked against a tag-order scoreboard.
module tb_reorder_buffer;
  localparam int ROB_SIZE = 16;
  localparam int DW       = 64;
  localparam int RAW      = 5;
  localparam int TW       = 5;
  localparam int CP       = 2;
  localparam int RW       = 2;
  localparam int LP       = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_SIZE(ROB_SIZE), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .TAG_WIDTH(TW),
                      .CDB_PORTS(CP), .RETIRE_WIDTH(RW), .LOOKUP_PORTS(LP)) rif ();

  reorder_buffer #(.ROB_SIZE(ROB_SIZE), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .TAG_WIDTH(TW),
                   .CDB_PORTS(CP), .RETIRE_WIDTH(RW), .LOOKUP_PORTS(LP)) dut (
    .clk    (clk),
    .reset  (reset),
    .rob_if (rif)
  );

  int total = 0;
  int bad   = 0;

  int              sb[$];
  logic [RAW-1:0]  exp_rd    [1:16];
  logic            exp_regwr [1:16];
  logic [DW-1:0]   exp_val   [1:16];
  logic [63:0]     exp_pc    [1:16];
  int              m_tail = 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rif.dispatch_valid = 1'b0;
    rif.dispatch_rd    = '0;
    rif.dispatch_regwr = 1'b0;
    rif.dispatch_pc    = '0;
    rif.cdb_valid      = '0;
    rif.cdb_tag        = '0;
    rif.cdb_value      = '0;
    rif.lookup_tag     = '0;
    rif.flush_valid    = 1'b0;
    rif.flush_tag      = '0;
    rif.flush_all      = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    sb.delete();
    m_tail = 1;
    #2;
    reset = 1'b1;
  endtask

  task automatic disp(input int rd);
    rif.dispatch_valid  = 1'b1;
    rif.dispatch_rd     = RAW'(rd);
    rif.dispatch_regwr  = rd[0];
    rif.dispatch_pc     = 64'h1000 + 64'(rd * 4);
    sb.push_back(m_tail);
    exp_rd[m_tail]    = RAW'(rd);
    exp_regwr[m_tail] = rd[0];
    exp_pc[m_tail]    = 64'h1000 + 64'(rd * 4);
    m_tail = (m_tail == ROB_SIZE) ? 1 : m_tail + 1;
    tick();
    rif.dispatch_valid = 1'b0;
  endtask

  task automatic cdb2(input logic v0, input int t0, input logic [DW-1:0] d0,
                      input logic v1, input int t1, input logic [DW-1:0] d1);
    rif.cdb_valid = {v1, v0};
    rif.cdb_tag   = {TW'(t1), TW'(t0)};
    rif.cdb_value = {d1, d0};
    if (v0) exp_val[t0] = d0;
    if (v1 && !(v0 && t0 == t1)) exp_val[t1] = d1;
    tick();
    rif.cdb_valid = '0;
  endtask

  // Scoreboard: every retiring lane must be the oldest outstanding tag with its expected payload.
  always @(negedge clk) begin
    int t;
    if (reset) begin
      total++;
      if (rif.retire_valid == 2'b10) begin
        bad++;
        $display("FAIL retire_contiguous: retire_valid=%b", rif.retire_valid);
      end
      for (int k = 0; k < RW; k++) begin
        if (rif.retire_valid[k]) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL retire_unexpected: lane %0d tag=%0d with empty scoreboard",
                     k, rif.retire_tag[k*TW +: TW]);
          end else begin
            t = sb.pop_front();
            if (rif.retire_tag[k*TW +: TW] !== TW'(t) ||
                rif.retire_rd[k*RAW +: RAW] !== exp_rd[t] ||
                rif.retire_regwr[k] !== exp_regwr[t] ||
                rif.retire_pc[k*64 +: 64] !== exp_pc[t] ||
                rif.retire_value[k*DW +: DW] !== exp_val[t]) begin
              bad++;
              $display("FAIL retire_lane%0d: got tag=%0d rd=%0d value=%h, want tag=%0d rd=%0d value=%h",
                       k, rif.retire_tag[k*TW +: TW], rif.retire_rd[k*RAW +: RAW],
                       rif.retire_value[k*DW +: DW], t, exp_rd[t], exp_val[t]);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    idle_inputs();
    rif.lookup_tag = {TW'(2), TW'(1)};
    #1;
    total++;
    if (rif.retire_valid !== 2'b00 || rif.dispatch_ready !== 1'b1 || rif.dispatch_tag !== TW'(1) ||
        rif.empty !== 1'b1 || rif.full !== 1'b0 || rif.count !== TW'(0) || rif.lookup_ready !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: rv=%b rdy=%b tag=%0d empty=%b full=%b count=%0d lr=%b, want 00 1 1 1 0 0 00",
               rif.retire_valid, rif.dispatch_ready, rif.dispatch_tag, rif.empty, rif.full,
               rif.count, rif.lookup_ready);
    end
    tick();
    reset = 1'b1;
    rif.lookup_tag = '0;
    tick();
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 1; i <= ROB_SIZE; i++) begin
      total++;
      if (rif.dispatch_tag !== TW'(i) || rif.dispatch_ready !== 1'b1) begin
        bad++;
        $display("FAIL fill_tag: got tag=%0d ready=%b, want tag=%0d ready=1",
                 rif.dispatch_tag, rif.dispatch_ready, i);
      end
      disp(i);
    end
    total++;
    if (rif.full !== 1'b1 || rif.count !== TW'(16) || rif.dispatch_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_full: full=%b count=%0d ready=%b, want 1 16 0",
               rif.full, rif.count, rif.dispatch_ready);
    end
    rif.dispatch_valid = 1'b1;
    rif.dispatch_rd    = RAW'(17);
    tick();
    rif.dispatch_valid = 1'b0;
    total++;
    if (rif.count !== TW'(16) || rif.dispatch_tag !== TW'(1)) begin
      bad++;
      $display("FAIL fill_reject: count=%0d tag=%0d, want 16 1", rif.count, rif.dispatch_tag);
    end
    for (int j = 0; j < 8; j++) cdb2(1'b1, 2*j+1, 64'(100 + j), 1'b1, 2*j+2, 64'(200 + j));
    for (int n = 0; n < 40 && rif.empty !== 1'b1; n++) tick();
    total++;
    if (rif.empty !== 1'b1 || sb.size() != 0) begin
      bad++;
      $display("FAIL fill_drain: empty=%b outstanding=%0d, want 1 0", rif.empty, sb.size());
    end
  endtask

  task automatic test_ooo_retire();
    apply_reset();
    disp(1); disp(2); disp(3);
    cdb2(1'b1, 2, 64'hAA, 1'b0, 0, 64'h0);
    rif.cdb_valid = 2'b10;
    rif.cdb_tag   = {TW'(1), TW'(0)};
    rif.cdb_value = {64'h55, 64'h0};
    exp_val[1]    = 64'h55;
    #1;
    total++;
    if (rif.retire_valid !== 2'b00) begin
      bad++;
      $display("FAIL ooo_hold: retire_valid=%b, want 00", rif.retire_valid);
    end
    tick();
    rif.cdb_valid = '0;
    total++;
    if (rif.retire_valid !== 2'b11 || rif.retire_tag !== {TW'(2), TW'(1)} ||
        rif.retire_value !== {64'hAA, 64'h55} || rif.count !== TW'(3)) begin
      bad++;
      $display("FAIL ooo_retire: rv=%b tags=%h vals=%h count=%0d, want 11 tags 2,1 vals AA,55 count 3",
               rif.retire_valid, rif.retire_tag, rif.retire_value, rif.count);
    end
    tick();
    total++;
    if (rif.count !== TW'(1) || rif.retire_valid !== 2'b00 || rif.dispatch_tag !== TW'(4)) begin
      bad++;
      $display("FAIL ooo_after: count=%0d rv=%b tag=%0d, want 1 00 4",
               rif.count, rif.retire_valid, rif.dispatch_tag);
    end
  endtask

  task automatic test_lookup_bypass();
    rif.lookup_tag = {TW'(2), TW'(3)};
    #1;
    total++;
    if (rif.lookup_ready !== 2'b00) begin
      bad++;
      $display("FAIL lookup_pending: lookup_ready=%b, want 00", rif.lookup_ready);
    end
    rif.cdb_valid = 2'b10;
    rif.cdb_tag   = {TW'(3), TW'(0)};
    rif.cdb_value = {64'h1234, 64'h0};
    exp_val[3]    = 64'h1234;
    #1;
    total++;
    if (rif.lookup_ready !== 2'b01 || rif.lookup_value !== {64'h0, 64'h1234}) begin
      bad++;
      $display("FAIL lookup_bypass: ready=%b value=%h, want 01 value0=1234 value1=0",
               rif.lookup_ready, rif.lookup_value);
    end
    tick();
    rif.cdb_valid = '0;
    total++;
    if (rif.lookup_ready[0] !== 1'b1 || rif.lookup_value[DW-1:0] !== 64'h1234) begin
      bad++;
      $display("FAIL lookup_stored: ready=%b value=%h, want 1 1234",
               rif.lookup_ready[0], rif.lookup_value[DW-1:0]);
    end
    tick();
    rif.lookup_tag = '0;
    total++;
    if (rif.empty !== 1'b1) begin
      bad++;
      $display("FAIL lookup_drain: empty=%b, want 1", rif.empty);
    end
  endtask

  task automatic test_wrap_flush();
    apply_reset();
    for (int i = 1; i <= 14; i++) disp(i);
    for (int j = 0; j < 7; j++) cdb2(1'b1, 2*j+1, 64'(300 + j), 1'b1, 2*j+2, 64'(400 + j));
    for (int n = 0; n < 40 && rif.empty !== 1'b1; n++) tick();
    total++;
    if (rif.empty !== 1'b1 || rif.dispatch_tag !== TW'(15)) begin
      bad++;
      $display("FAIL wrap_setup: empty=%b tag=%0d, want 1 15", rif.empty, rif.dispatch_tag);
    end
    disp(15); disp(16); disp(21); disp(22);
    rif.flush_valid = 1'b1;
    rif.flush_tag   = TW'(16);
    rif.cdb_valid   = 2'b01;
    rif.cdb_tag     = {TW'(0), TW'(1)};
    rif.cdb_value   = {64'h0, 64'h77};
    #1;
    total++;
    if (rif.dispatch_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready: dispatch_ready=%b, want 0", rif.dispatch_ready);
    end
    tick();
    rif.flush_valid = 1'b0;
    rif.cdb_valid   = '0;
    void'(sb.pop_back());
    void'(sb.pop_back());
    m_tail = 1;
    rif.lookup_tag = {TW'(2), TW'(1)};
    #1;
    total++;
    if (rif.lookup_ready !== 2'b00 || rif.count !== TW'(2) || rif.dispatch_tag !== TW'(1)) begin
      bad++;
      $display("FAIL flush_state: lr=%b count=%0d tag=%0d, want 00 2 1",
               rif.lookup_ready, rif.count, rif.dispatch_tag);
    end
    rif.lookup_tag = '0;
    cdb2(1'b1, 15, 64'hF15, 1'b1, 16, 64'hF16);
    for (int n = 0; n < 20 && rif.empty !== 1'b1; n++) tick();
    total++;
    if (rif.empty !== 1'b1 || rif.dispatch_tag !== TW'(1) || sb.size() != 0) begin
      bad++;
      $display("FAIL wrap_drain: empty=%b tag=%0d outstanding=%0d, want 1 1 0",
               rif.empty, rif.dispatch_tag, sb.size());
    end
  endtask

  task automatic test_cdb_priority();
    apply_reset();
    for (int i = 1; i <= 5; i++) disp(i);
    cdb2(1'b1, 5, 64'd7, 1'b1, 5, 64'd9);
    rif.lookup_tag = {TW'(0), TW'(5)};
    #1;
    total++;
    if (rif.lookup_ready !== 2'b01 || rif.lookup_value !== {64'h0, 64'd7}) begin
      bad++;
      $display("FAIL cdb_priority: ready=%b value=%h, want 01 value0=7 value1=0",
               rif.lookup_ready, rif.lookup_value);
    end
    rif.lookup_tag = '0;
    cdb2(1'b1, 1, 64'h11, 1'b0, 0, 64'h0);
    rif.flush_all = 1'b1;
    #1;
    total++;
    if (rif.retire_valid !== 2'b00 || rif.dispatch_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_all_cycle: rv=%b ready=%b, want 00 0", rif.retire_valid, rif.dispatch_ready);
    end
    tick();
    rif.flush_all = 1'b0;
    sb.delete();
    m_tail = 1;
    total++;
    if (rif.count !== TW'(0) || rif.empty !== 1'b1 || rif.dispatch_tag !== TW'(1)) begin
      bad++;
      $display("FAIL flush_all_after: count=%0d empty=%b tag=%0d, want 0 1 1",
               rif.count, rif.empty, rif.dispatch_tag);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 1; i <= 5; i++) disp(i);
    cdb2(1'b1, 1, 64'hABC, 1'b0, 0, 64'h0);
    total++;
    if (rif.retire_valid !== 2'b01 || rif.count !== TW'(5)) begin
      bad++;
      $display("FAIL async_pre: rv=%b count=%0d, want 01 5", rif.retire_valid, rif.count);
    end
    reset = 1'b0;
    sb.delete();
    m_tail = 1;
    #1;
    total++;
    if (rif.retire_valid !== 2'b00 || rif.dispatch_tag !== TW'(1) || rif.count !== TW'(0) ||
        rif.empty !== 1'b1 || rif.full !== 1'b0 || rif.dispatch_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: rv=%b tag=%0d count=%0d empty=%b full=%b rdy=%b, want 00 1 0 1 0 1",
               rif.retire_valid, rif.dispatch_tag, rif.count, rif.empty, rif.full, rif.dispatch_ready);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (rif.dispatch_tag !== TW'(1) || rif.empty !== 1'b1) begin
      bad++;
      $display("FAIL async_release: tag=%0d empty=%b, want 1 1", rif.dispatch_tag, rif.empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo_retire();
    test_lookup_bypass();
    test_wrap_flush();
    test_cdb_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Parametrised reorder buffer for the out-of-order core. It replaces the ad-hoc ROB array and head/tail logic in the top level with a self-contained block. The block allocates tags at dispatch and captures results from N common data buses (CDBs). It retires up to RETIRE_WIDTH in-order entries per cycle, answers operand-lookup reads, and supports selective flush after a branch mispredict.

Parameters:
ROB_SIZE, 16, number of entries; tags are 1..ROB_SIZE, and tag 0 means "no tag"
DATA_WIDTH, 64, result value width
REG_ADDR_WIDTH, 5, architectural register index width
TAG_WIDTH, $clog2(ROB_SIZE+1), tag width
CDB_PORTS, 2, number of CDB write channels
RETIRE_WIDTH, 2, maximum retirements per cycle
LOOKUP_PORTS, 2, number of operand-lookup read ports

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
dispatch_valid  in  1  request to allocate one entry
dispatch_rd  in  REG_ADDR_WIDTH  destination register
dispatch_regwr  in  1  entry writes a register
dispatch_pc  in  64  instruction PC
dispatch_ready  out  1  allocation is accepted this cycle
dispatch_tag  out  TAG_WIDTH  tag given to the accepted dispatch (the tail tag)
cdb_valid  in  CDB_PORTS  per-channel valid
cdb_tag  in  CDB_PORTS*TAG_WIDTH  completing tags
cdb_value  in  CDB_PORTS*DATA_WIDTH  completing values
lookup_tag  in  LOOKUP_PORTS*TAG_WIDTH  tags to query
lookup_ready  out  LOOKUP_PORTS  entry holds a value
lookup_value  out  LOOKUP_PORTS*DATA_WIDTH  that value
flush_valid  in  1  selective flush request
flush_tag  in  TAG_WIDTH  youngest surviving tag
flush_all  in  1  discard every entry
retire_valid  out  RETIRE_WIDTH  per-lane retire; lanes are contiguous from lane 0
retire_tag  out  RETIRE_WIDTH*TAG_WIDTH  retiring tags
retire_rd  out  RETIRE_WIDTH*REG_ADDR_WIDTH  retiring destinations
retire_regwr  out  RETIRE_WIDTH  register write enables
retire_value  out  RETIRE_WIDTH*DATA_WIDTH  retiring values
count  out  $clog2(ROB_SIZE+1)  occupied entries
empty  out  1  count==0
full  out  1  count==ROB_SIZE

Behaviour:
- Slot i permanently carries tag i+1.
- State: head and tail pointers (0..ROB_SIZE-1), count, and per slot busy/ready/regwr/rd/pc/value.
- Reset (asynchronous, reset==0):
  - head=tail=count=0; all busy/ready bits cleared.
  - Outputs: retire_valid=0, dispatch_ready=1, dispatch_tag=1, empty=1, full=0, lookup_ready=0.
- Dispatch:
  - dispatch_ready = !full && !flush_valid && !flush_all. Freed-slot credit from a same-cycle retire is not used.
  - On dispatch_valid && dispatch_ready, at the edge: the tail slot gets busy=1, ready=0 and the inputs are stored; tail advances by one and wraps from ROB_SIZE-1 to 0.
  - dispatch_tag = tail+1, combinational.
- CDB capture:
  - For each valid channel whose tag names a busy, not-flushed slot: set ready=1 and store the value at the edge.
  - Tag 0, or a tag naming a non-busy slot, is ignored.
  - Two channels with the same tag in the same cycle: the lower channel index wins.
- Lookup:
  - Combinational. A tag that matches a same-cycle valid CDB channel returns that CDB value with ready=1 (bypass; the lowest channel wins).
  - Otherwise the port returns the slot's ready bit and value.
  - Tag 0 or a non-busy slot gives ready=0, value=0.
- Retire:
  - Combinational from registered state. Lane k is valid iff lanes 0..k-1 are valid and slot (head+k) mod ROB_SIZE is busy and ready.
  - At the edge the retired slots are cleared and head advances by the number of valid lanes.
  - An entry completed by CDB in cycle N can retire no earlier than cycle N+1.
  - Retire never stalls on an external signal.
- Count: count_next = count + accepted dispatch - retired lanes - flushed entries. Simultaneous dispatch and retire is legal.
- Selective flush (flush_valid, flush_tag naming a busy slot F):
  - Every busy slot strictly younger than F is cleared.
  - tail = (F+1) mod ROB_SIZE; count is recomputed from head, tail and retirements.
  - Retirements in the same cycle still complete, since they are older than or equal to F.
  - CDB writes to flushed slots are dropped.
  - A flush_tag naming a non-busy slot, or tag 0, is ignored.
- flush_all:
  - Clears every slot; head=tail=count=0 at the edge.
  - retire_valid is forced to 0 that cycle.
  - Has priority over flush_valid.
- Wrap-around: head, tail and F comparisons use age relative to head, never raw slot index.

Test Plan:
- Reset, then dispatch 16 entries with rd=1..16 → dispatch_tag goes 1..16; full=1 after the 16th; the 17th dispatch is not accepted and tail stays 0.
- Dispatch tags 1,2,3; CDB ch0 tag 2 value 0xAA in cycle N; ch1 tag 1 value 0x55 in cycle N+1 → in N+2 lanes 0 and 1 retire tags 1 and 2 with values 0x55 and 0xAA; tag 3 does not retire; count=1.
- lookup_tag=3 while cdb ch1 carries tag 3 value 0x1234 → lookup_ready=1, lookup_value=0x1234 in the same cycle; the next cycle returns the same value from storage.
- Head at slot 14; dispatch tags 15,16,1,2; flush_valid with flush_tag=16 → tail=0, count=2, and tags 1 and 2 are invalid (lookup_ready=0).
- Both CDB channels carry tag 5 with values 7 and 9 → stored value is 7.
- Deassert reset (drive low) mid-stream with 5 busy entries → outputs return to reset values immediately, without waiting for a clk edge; after release, dispatch_tag=1.
